// File: rtl/dii_pkg.sv
// ---------------------------------------------------------------------------
// dii_pkg
// Shared definitions for the DII (Debug Interconnect Interface) blocks:
// the flit type, the arbitration-mode selectors, the packet arbiter's FSM
// state type, and a small wrap-around index helper.
// No ports (package).
// ---------------------------------------------------------------------------
package dii_pkg;

  localparam int DII_DATA_WIDTH = 16;

  // Arbitration mode selectors for dii_packet_arbiter's ARB_MODE parameter.
  localparam int DII_ARB_RR    = 0;
  localparam int DII_ARB_FIXED = 1;

  typedef struct packed {
    logic                      last;
    logic [DII_DATA_WIDTH-1:0] data;
  } dii_flit;

  typedef enum logic {
    DII_ST_IDLE,
    DII_ST_LOCKED
  } dii_arb_state_e;

  // Index following idx, wrapping back to 0 at n.
  function automatic int dii_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dii_skid_fifo.sv
// ---------------------------------------------------------------------------
// dii_skid_fifo
// Two-entry FIFO that decouples the arbiter from the downstream port. The
// head entry comes straight from a register, and full/empty are derived
// from the registered occupancy only. This keeps downstream ready from
// reaching upstream ready combinationally.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous reset, active-low (clears entries to zero)
//   push_i   in   write wdata_i (ignored while full)
//   pop_i    in   drop the head entry (ignored while empty)
//   wdata_i  in   entry to write
//   rdata_o  out  head entry
//   full_o   out  both entries occupied
//   empty_o  out  no entry occupied
// ---------------------------------------------------------------------------
module dii_skid_fifo
  import dii_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy. A simultaneous push and pop leaves the
  // count unchanged, which is what allows one flit per cycle at count 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// ---------------------------------------------------------------------------
// dii_packet_arbiter
// Merges N DII input channels into one output channel. Arbitration is done
// per packet: once the first flit of a multi-flit packet is taken, its
// channel keeps the grant until the last flit, so packets never interleave.
// The arbitration is either round-robin or fixed priority (lowest index
// wins). A 2-entry buffer registers the output side.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   [N]             per-channel flit valid
//   in_last    in   [N]             per-channel last flit of packet
//   in_data    in   [N*DATA_WIDTH]  per-channel payload, channel i at slice i
//   in_ready   out  [N]             per-channel accept
//   out_valid  out  output flit valid
//   out_last   out  output last
//   out_data   out  [DATA_WIDTH]    output payload
//   out_ready  in   downstream accept
//   out_src    out  [IDXW]          source channel of the head flit
//   locked     out  a multi-flit packet is in progress
// ---------------------------------------------------------------------------
module dii_packet_arbiter
  import dii_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ARB_MODE   = DII_ARB_RR,
  parameter int IDXW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          in_valid,
  input  logic [N-1:0]          in_last,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [IDXW-1:0]       out_src,
  output logic                  locked
);

  localparam int ENTRY_W = 1 + DATA_WIDTH + IDXW;

  dii_arb_state_e        state_q;
  logic [IDXW-1:0]       rr_ptr_q;
  logic [IDXW-1:0]       grant_q;

  logic [IDXW-1:0]       winner;
  logic                  any_valid;
  logic [IDXW-1:0]       sel;
  logic                  space;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic [ENTRY_W-1:0]    head;

  assign any_valid = |in_valid;
  assign space     = !fifo_full;
  assign locked    = (state_q == DII_ST_LOCKED);

  // Candidate for a new packet. Round-robin scans from rr_ptr upwards and
  // wraps; fixed priority always scans from index 0, so rr_ptr is ignored.
  always_comb begin : pick_winner
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      if (ARB_MODE == DII_ARB_FIXED) begin
        idx = i;
      end else begin
        idx = (int'(rr_ptr_q) + i) % N;
      end
      if (!found && in_valid[idx]) begin
        winner = IDXW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign sel = locked ? grant_q : winner;

  // Only the selected channel can see ready. While locked, the granted
  // channel keeps ready even if it stalls, so nobody else slips in.
  always_comb begin
    in_ready = '0;
    if (rst_n && (locked || any_valid)) begin
      in_ready[sel] = space;
    end
  end

  assign push      = in_valid[sel] && in_ready[sel];
  assign push_last = in_last[sel];
  assign push_data = in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  // Packet-level FSM. The round-robin pointer only moves when a packet
  // completes, so the channel just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DII_ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else if (push) begin
      case (state_q)
        DII_ST_IDLE: begin
          if (push_last) begin
            rr_ptr_q <= IDXW'(dii_next_idx(int'(winner), N));
          end else begin
            state_q <= DII_ST_LOCKED;
            grant_q <= winner;
          end
        end
        DII_ST_LOCKED: begin
          if (push_last) begin
            state_q  <= DII_ST_IDLE;
            rr_ptr_q <= IDXW'(dii_next_idx(int'(grant_q), N));
          end
        end
        default: state_q <= DII_ST_IDLE;
      endcase
    end
  end

  dii_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (out_ready),
    .wdata_i ({push_last, push_data, sel}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = head[ENTRY_W-1];
  assign out_data  = head[IDXW +: DATA_WIDTH];
  assign out_src   = head[IDXW-1:0];

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dii_packet_arbiter
// Directed bench for dii_packet_arbiter. It drives two instances from the
// same inputs: dutR (round-robin) and dutF (fixed priority). The useFixed
// flag selects which instance is observed. Each channel has a small
// source model that presents its flits in order. Every flit loaded into a
// source is also pushed, in the order the bench predicts it will appear, onto
// an expected-output queue. That queue is popped whenever the observed
// output completes a transfer.
// ---------------------------------------------------------------------------
module tb_dii_packet_arbiter;
  import dii_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N*DW-1:0] in_data;
  logic            out_ready;

  logic [N-1:0]  rdyR, rdyF;
  logic          ovR, ovF, olR, olF, lkR, lkF;
  logic [DW-1:0] odR, odF;
  logic [IW-1:0] osR, osF;

  logic          useFixed;
  logic [N-1:0]  obsReady;
  logic          obsValid, obsLast, obsLocked;
  logic [DW-1:0] obsData;
  logic [IW-1:0] obsSrc;

  logic [DW:0]    srcMem [N][16];
  int             srcHead [N];
  int             srcTail [N];
  logic [IW+DW:0] expQ [$];

  int checks;
  int passes;

  always #5 clk = ~clk;

  dii_packet_arbiter #(.N(N), .DATA_WIDTH(DW), .ARB_MODE(DII_ARB_RR)) dutR (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(rdyR), .out_valid(ovR), .out_last(olR),
    .out_data(odR), .out_ready(out_ready), .out_src(osR), .locked(lkR)
  );

  dii_packet_arbiter #(.N(N), .DATA_WIDTH(DW), .ARB_MODE(DII_ARB_FIXED)) dutF (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(rdyF), .out_valid(ovF), .out_last(olF),
    .out_data(odF), .out_ready(out_ready), .out_src(osF), .locked(lkF)
  );

  assign obsReady  = useFixed ? rdyF : rdyR;
  assign obsValid  = useFixed ? ovF  : ovR;
  assign obsLast   = useFixed ? olF  : olR;
  assign obsData   = useFixed ? odF  : odR;
  assign obsSrc    = useFixed ? osF  : osR;
  assign obsLocked = useFixed ? lkF  : lkR;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic flushSources();
    for (int ch = 0; ch < N; ch++) begin
      srcHead[ch] = 0;
      srcTail[ch] = 0;
    end
    expQ.delete();
  endtask

  task automatic sendFlit(input int ch, input logic last, input logic [DW-1:0] data);
    srcMem[ch][srcTail[ch]] = {last, data};
    srcTail[ch]++;
    expQ.push_back({IW'(ch), last, data});
  endtask

  task automatic driveInputs();
    for (int ch = 0; ch < N; ch++) begin
      if (srcHead[ch] < srcTail[ch]) begin
        in_valid[ch] = 1'b1;
        {in_last[ch], in_data[ch*DW +: DW]} = srcMem[ch][srcHead[ch]];
      end else begin
        in_valid[ch]         = 1'b0;
        in_last[ch]          = 1'b0;
        in_data[ch*DW +: DW] = '0;
      end
    end
    #1;
  endtask

  // One clock cycle: sample handshakes at the falling edge, score any
  // output transfer, then advance sources past accepted flits.
  task automatic applyStimulus();
    logic [N-1:0]   acc;
    logic [IW+DW:0] got;
    logic [IW+DW:0] exp;
    @(negedge clk);
    acc = in_valid & obsReady;
    if (obsValid && out_ready) begin
      got = {obsSrc, obsLast, obsData};
      if (expQ.size() == 0) begin
        checkOutput("spurious_flit", 64'(got), 64'(1) << 40);
      end else begin
        exp = expQ.pop_front();
        checkOutput("out_flit", 64'(got), 64'(exp));
      end
    end
    @(posedge clk);
    #1;
    for (int ch = 0; ch < N; ch++) begin
      if (acc[ch]) srcHead[ch]++;
    end
    driveInputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
  endtask

  task automatic resetDut();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    flushSources();
    driveInputs();
    repeat (2) applyStimulus();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks    = 0;
    passes    = 0;
    useFixed  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '0;
    in_data   = '0;
    flushSources();
    repeat (2) @(posedge clk);
    #2;

    // Reset state, with every input valid to show ready is forced low.
    checkOutput("rst_ready_rr", 64'(rdyR), 64'(0));
    checkOutput("rst_ready_fx", 64'(rdyF), 64'(0));
    checkOutput("rst_out_valid", 64'(ovR), 64'(0));
    checkOutput("rst_out_last", 64'(olR), 64'(0));
    checkOutput("rst_out_data", 64'(odR), 64'(0));
    checkOutput("rst_out_src", 64'(osR), 64'(0));
    checkOutput("rst_locked", 64'(lkR), 64'(0));

    // Single channel: ch2 sends a 3-flit packet.
    resetDut();
    sendFlit(2, 1'b0, 16'h00A1);
    sendFlit(2, 1'b0, 16'h00A2);
    sendFlit(2, 1'b1, 16'h00A3);
    driveInputs();
    checkOutput("t1_ready_c0", 64'(rdyR), 64'(4'b0100));
    checkOutput("t1_locked_c0", 64'(lkR), 64'(0));
    applyStimulus();
    checkOutput("t1_valid_c1", 64'(ovR), 64'(1));
    checkOutput("t1_data_c1", 64'(odR), 64'(16'h00A1));
    checkOutput("t1_locked_c1", 64'(lkR), 64'(1));
    applyStimulus();
    checkOutput("t1_locked_c2", 64'(lkR), 64'(1));
    applyStimulus();
    checkOutput("t1_locked_c3", 64'(lkR), 64'(0));
    checkOutput("t1_last_c3", 64'(olR), 64'(1));
    drain(8);

    // Round-robin fairness: all channels busy with single-flit packets.
    resetDut();
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        sendFlit(ch, 1'b1, 16'hB000 | 16'(ch << 8) | 16'(k));
      end
    end
    driveInputs();
    applyStimulus();
    for (int i = 0; i < 12; i++) begin
      checkOutput("rr_no_bubble", 64'(ovR), 64'(1));
      applyStimulus();
    end
    drain(4);

    // No interleaving: ch1 arrives while ch0's 4-flit packet is in flight.
    resetDut();
    sendFlit(0, 1'b0, 16'hB0B0);
    sendFlit(0, 1'b0, 16'hB0B1);
    sendFlit(0, 1'b0, 16'hB0B2);
    sendFlit(0, 1'b1, 16'hB0B3);
    driveInputs();
    applyStimulus();
    sendFlit(1, 1'b0, 16'hC1C0);
    sendFlit(1, 1'b1, 16'hC1C1);
    driveInputs();
    for (int c = 1; c <= 3; c++) begin
      checkOutput("nil_ready1_locked", 64'(rdyR[1]), 64'(0));
      applyStimulus();
    end
    checkOutput("nil_ready1_after", 64'(rdyR[1]), 64'(1));
    drain(10);

    // Backpressure: out_ready low for 5 cycles in the middle of a packet.
    resetDut();
    for (int i = 0; i < 8; i++) begin
      sendFlit(0, (i == 7), 16'hD000 + 16'(i));
    end
    driveInputs();
    applyStimulus();
    applyStimulus();
    out_ready = 1'b0;
    #1;
    checkOutput("bp_ready_c2", 64'(rdyR), 64'(4'b0001));
    applyStimulus();
    for (int c = 3; c <= 6; c++) begin
      checkOutput("bp_ready_full", 64'(rdyR), 64'(0));
      checkOutput("bp_valid_hold", 64'(ovR), 64'(1));
      checkOutput("bp_head_hold", 64'(odR), 64'(16'hD001));
      applyStimulus();
    end
    out_ready = 1'b1;
    drain(16);

    // Fixed priority: rr_ptr is first pushed to 3, which must not matter.
    useFixed = 1'b1;
    resetDut();
    sendFlit(2, 1'b1, 16'h6060);
    driveInputs();
    drain(6);
    sendFlit(1, 1'b0, 16'hE100);
    sendFlit(1, 1'b1, 16'hE101);
    sendFlit(1, 1'b0, 16'hE102);
    sendFlit(1, 1'b1, 16'hE103);
    sendFlit(3, 1'b0, 16'hF300);
    sendFlit(3, 1'b1, 16'hF301);
    sendFlit(3, 1'b0, 16'hF302);
    sendFlit(3, 1'b1, 16'hF303);
    driveInputs();
    checkOutput("fx_first_ready", 64'(obsReady), 64'(4'b0010));
    drain(20);
    checkOutput("fx_unlocked", 64'(obsLocked), 64'(0));
    useFixed = 1'b0;

    // Reset during flit 2 of a 4-flit packet, with rr_ptr previously at 2.
    resetDut();
    sendFlit(1, 1'b1, 16'h1111);
    driveInputs();
    drain(6);
    sendFlit(2, 1'b0, 16'h2220);
    sendFlit(2, 1'b0, 16'h2221);
    sendFlit(2, 1'b0, 16'h2222);
    sendFlit(2, 1'b1, 16'h2223);
    driveInputs();
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready_now", 64'(rdyR), 64'(0));
    applyStimulus();
    checkOutput("mid_rst_valid", 64'(ovR), 64'(0));
    checkOutput("mid_rst_locked", 64'(lkR), 64'(0));
    checkOutput("mid_rst_ready", 64'(rdyR), 64'(0));
    flushSources();
    rst_n = 1'b1;
    sendFlit(1, 1'b1, 16'h3331);
    sendFlit(3, 1'b1, 16'h3333);
    driveInputs();
    checkOutput("mid_rst_restart", 64'(rdyR), 64'(4'b0010));
    drain(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
